alu_response_checker: RTL

//  Responder end of the ALU test-vector interface: accepts one vector {Opcode, FuncCode, A, B, expected}

---
 rtl/alu_response_checker_pkg.sv | 30 +++
 rtl/alu_response_checker_sat_counter.sv | 35 +++
 rtl/alu_response_checker.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_response_checker_pkg.sv
// Shared definitions for the ALU response checker: FSM states and ALU encodings.
package alu_response_checker_pkg;

  // Checker FSM states; StIdle must encode as zero (reset state)
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2,
    StReport = 2'd3
  } state_e;

  // Width of the settle counter (SETTLE_CYCLES is limited to 1..15)
  localparam int unsigned SettleW = 4;

  // Opcodes seen by ALUControl
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // FuncCode = {instr[30], instr[14:12]}
  localparam logic [3:0] FC_ADD = 4'b0000;
  localparam logic [3:0] FC_SUB = 4'b1000;
  localparam logic [3:0] FC_SLL = 4'b0001;
  localparam logic [3:0] FC_SLT = 4'b0010;
  localparam logic [3:0] FC_XOR = 4'b0100;
  localparam logic [3:0] FC_SRL = 4'b0101;
  localparam logic [3:0] FC_SRA = 4'b1101;
  localparam logic [3:0] FC_OR  = 4'b0110;
  localparam logic [3:0] FC_AND = 4'b0111;

endpackage

// File: rtl/alu_response_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module alu_response_checker_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear, else increment unless already all-ones
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/alu_response_checker.sv
// Responder end of the ALU test-vector interface: accepts a vector, drives the ALU,
// waits SETTLE_CYCLES, samples and compares, keeps pass/fail tallies and the first failure.
module alu_response_checker
  import alu_response_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned IDX_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [6:0]       vec_opcode,
  input  logic [3:0]       vec_funccode,
  input  logic [31:0]      vec_a,
  input  logic [31:0]      vec_b,
  input  logic [31:0]      vec_exp_out,
  input  logic             vec_exp_branch,
  input  logic             vec_chk_branch,
  output logic [6:0]       alu_opcode,
  output logic [3:0]       alu_funccode,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_branch,
  output logic             res_valid,
  output logic             res_pass,
  output logic [31:0]      res_got,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_vld,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             busy
);

  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;

  logic [SettleW-1:0] settle_q, settle_d;
  logic               vec_ready_q, vec_ready_d;

  // Latched vector
  logic [6:0]  op_q, op_d;
  logic [3:0]  fc_q, fc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] exp_out_q, exp_out_d;
  logic        exp_br_q, exp_br_d;
  logic        chk_br_q, chk_br_d;

  // Result and log
  logic [31:0]      got_q, got_d;
  logic             pass_q, pass_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ff_vld_q, ff_vld_d;
  logic [IDX_W-1:0] ff_idx_q, ff_idx_d;

  logic accept;
  logic report;
  logic pass_inc;
  logic fail_inc;

  assign accept = (state_q == StIdle) && vec_ready_q && vec_valid;
  assign report = (state_q == StReport);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDrive;
      StDrive:  if (settle_q == SettleLast) state_d = StSample;
      StSample: state_d = StReport;
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: result strobe in REPORT, busy outside IDLE
  always_comb begin
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle:   busy      = 1'b0;
      StReport: res_valid = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next-state: vector latch, settle count, sample/compare, index and first-fail log
  always_comb begin
    settle_d  = '0;
    op_d      = op_q;
    fc_d      = fc_q;
    a_d       = a_q;
    b_d       = b_q;
    exp_out_d = exp_out_q;
    exp_br_d  = exp_br_q;
    chk_br_d  = chk_br_q;
    got_d     = got_q;
    pass_d    = pass_q;
    idx_d     = idx_q;
    ff_vld_d  = ff_vld_q;
    ff_idx_d  = ff_idx_q;
    // Registered ready: high whenever the FSM will sit in IDLE next cycle
    vec_ready_d = (state_d == StIdle);

    if (accept) begin
      op_d      = vec_opcode;
      fc_d      = vec_funccode;
      a_d       = vec_a;
      b_d       = vec_b;
      exp_out_d = vec_exp_out;
      exp_br_d  = vec_exp_branch;
      chk_br_d  = vec_chk_branch;
    end

    if (state_q == StDrive) begin
      settle_d = settle_q + SettleW'(1);
    end

    if (state_q == StSample) begin
      got_d  = alu_out;
      pass_d = (alu_out == exp_out_q) && (!chk_br_q || (alu_branch == exp_br_q));
    end

    // Clear beats the REPORT bookkeeping; the strobe itself still fires
    if (clear) begin
      idx_d    = '0;
      ff_vld_d = 1'b0;
      ff_idx_d = '0;
    end else if (report) begin
      idx_d = idx_q + IDX_W'(1);
      if (!pass_q && !ff_vld_q) begin
        ff_vld_d = 1'b1;
        ff_idx_d = idx_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q    <= '0;
      vec_ready_q <= 1'b0;
      op_q        <= '0;
      fc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      exp_out_q   <= '0;
      exp_br_q    <= 1'b0;
      chk_br_q    <= 1'b0;
      got_q       <= '0;
      pass_q      <= 1'b0;
      idx_q       <= '0;
      ff_vld_q    <= 1'b0;
      ff_idx_q    <= '0;
    end else begin
      settle_q    <= settle_d;
      vec_ready_q <= vec_ready_d;
      op_q        <= op_d;
      fc_q        <= fc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exp_out_q   <= exp_out_d;
      exp_br_q    <= exp_br_d;
      chk_br_q    <= chk_br_d;
      got_q       <= got_d;
      pass_q      <= pass_d;
      idx_q       <= idx_d;
      ff_vld_q    <= ff_vld_d;
      ff_idx_q    <= ff_idx_d;
    end
  end

  assign pass_inc = report && !clear && pass_q;
  assign fail_inc = report && !clear && !pass_q;

  alu_response_checker_sat_counter #(
    .Width (CNT_W)
  ) u_pass_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .inc_i   (pass_inc),
    .count_o (pass_count)
  );

  alu_response_checker_sat_counter #(
    .Width (CNT_W)
  ) u_fail_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .inc_i   (fail_inc),
    .count_o (fail_count)
  );

  assign vec_ready      = vec_ready_q;
  assign alu_opcode     = op_q;
  assign alu_funccode   = fc_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign res_pass       = pass_q;
  assign res_got        = got_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_idx = ff_idx_q;

endmodule
